cam_axi_wr_slave: RTL and testbench
===================================

Name: cam_axi_wr_slave

Overview:
- AXI4 single-beat write responder; the target end of the camera-to-SPI pixel path.
- Decodes writes to two addresses: the SPI address register (SPIADR) and the transmit FIFO (TXFIFO).
- Stores each RAM address word in a register and pushes each pixel word into an internal FIFO. A downstream SPI/stream consumer drains that FIFO.
- Returns a B response for every accepted transaction and flags address-sequence errors.

Parameters:
- AXI4_ADDRESS_WIDTH, 32, AW address width
- AXI4_WDATA_WIDTH, 32, W data width (fixed 32 in this block)
- AXI4_ID_WIDTH, 16, AW/B id width
- AXI4_USER_WIDTH, 10, user width (ignored on input, driven 0 on B)
- TXFIFO, 32'h1A102018, pixel-data write address
- SPIADR, 32'h0A10200C, RAM-address write address
- FIFO_DEPTH, 4, pixel FIFO depth in words (power of 2, ≥2)

Ports:
- iclk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- aw_id_i  in  ID_WIDTH  write id
- aw_addr_i  in  ADDRESS_WIDTH  write address
- aw_len_i  in  8  burst length
- aw_size_i  in  3  beat size
- aw_burst_i  in  2  burst type (ignored)
- aw_valid_i  in  1  address valid
- aw_ready_o  out  1  address ready
- w_data_i  in  32  write data
- w_strb_i  in  4  byte strobes
- w_last_i  in  1  last beat
- w_valid_i  in  1  data valid
- w_ready_o  out  1  data ready
- b_id_o  out  ID_WIDTH  response id (echo of captured aw_id_i)
- b_resp_o  out  2  00 OKAY, 10 SLVERR
- b_user_o  out  USER_WIDTH  constant 0
- b_valid_o  out  1  response valid
- b_ready_i  in  1  response ready
- ram_addr_o  out  32  last RAM address written via SPIADR
- ram_addr_upd_o  out  1  one-cycle pulse when ram_addr_o changes
- pix_data_o  out  32  FIFO head word
- pix_valid_o  out  1  FIFO not empty
- pix_ready_i  in  1  consumer pop
- word_cnt_o  out  16  pixel words accepted since last SPIADR write
- seq_err_o  out  1  sticky: SPIADR value ≠ previous+4 (after first)
- seq_clr_i  in  1  clears seq_err_o

Behaviour:
- Interface: one clock (iclk); reset rst is asynchronous, active-high.
- Reset values:
  - FSM = IDLE; all ready/valid outputs 0.
  - b_resp_o = 00, ram_addr_o = 0, word_cnt_o = 0, seq_err_o = 0.
  - FIFO empty; internal first_addr flag = 1.
- FSM states: IDLE, DATA, RESP.
  - IDLE: aw_ready_o = 1. On aw_valid_i, capture id, addr, err_len = (aw_len_i≠0 or aw_size_i≠3'b010), then go to DATA.
  - DATA: decode the captured address.
    - TXFIFO: w_ready_o = !fifo_full.
    - SPIADR or unmapped: w_ready_o = 1.
    - On the W handshake, go to RESP.
  - RESP: b_valid_o = 1, held until b_ready_i, then go to IDLE.
- Minimum transaction: AW at cycle 0, W at cycle 1, B valid at cycle 2, IDLE at cycle 3. Only one transaction is in flight; aw_ready_o is 0 outside IDLE.
- Error rules: SLVERR if the address is unmapped, err_len is set, w_last_i = 0, or w_strb_i ≠ 4'hF.
  - On SLVERR no side effect occurs: no FIFO push and no register update.
  - Otherwise the response is OKAY.
- SPIADR write (OKAY):
  - ram_addr_o ← w_data_i; ram_addr_upd_o pulses one cycle later; word_cnt_o ← 0.
  - If first_addr = 0 and w_data_i ≠ ram_addr_o+4, set seq_err_o. Then first_addr ← 0.
- TXFIFO write (OKAY): push w_data_i; word_cnt_o increments, saturating at 16'hFFFF.
- FIFO is first-word-fall-through.
  - Pop occurs when pix_valid_o & pix_ready_i.
  - A simultaneous push and pop while full is not possible, because w_ready_o is gated on full.
  - A simultaneous push and pop at any other occupancy keeps the count unchanged.
- seq_clr_i clears seq_err_o and takes priority over a same-cycle set. It also sets first_addr = 1.
- ram_addr_o arithmetic is modulo 2^32: 32'hFFFFFFFC followed by 32'h0 is in sequence.
- Reset mid-transaction aborts it. No B is issued for an aborted transaction, and the FIFO contents are lost.

Decomposition:
- Package cam_axi_pkg holds:
  - FSM state enum {IDLE, DATA, RESP}
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - TXFIFO/SPIADR default constants, shared with the camera master
- One sub-module: cam_sync_fifo, a parameterised width/depth single-clock FWFT FIFO with full/empty flags.

Test Plan:
- SPIADR write 32'h7FF, OKAY → b_resp_o = 00, b_id_o = aw_id_i, ram_addr_o = 32'h7FF, one ram_addr_upd_o pulse, word_cnt_o = 0.
- Four TXFIFO writes 32'h11, 32'h22, 32'h33, 32'h44 with pix_ready_i = 0 → FIFO full. A fifth W is stalled with w_ready_o = 0 until one pop. Pops return 11, 22, 33, 44 in order, followed by the fifth word.
- SPIADR writes 32'h7FF then 32'h803 → seq_err_o stays 0. A following write of 32'h900 → seq_err_o = 1. seq_clr_i → 0.
- Write to 32'h0 → SLVERR with no state change. A TXFIFO write with aw_len_i = 1 → SLVERR with no push. A TXFIFO write with w_strb_i = 4'h3 → SLVERR.
- b_ready_i held 0 for 5 cycles → b_valid_o stays 1 and aw_ready_o stays 0. Release → IDLE next cycle.
- Assert rst while in DATA → all outputs return to reset values asynchronously, and the next transaction completes normally.

Source files
------------

// File: rtl/cam_axi_pkg.sv
// Shared definitions for the camera-to-SPI AXI write path.
// Holds the responder FSM states, the AXI response codes and the two decoded
// register addresses (also used by the camera master side).
package cam_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] TXFIFO_ADDR = 32'h1A10_2018;
  localparam logic [31:0] SPIADR_ADDR = 32'h0A10_200C;

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write side (ignored while full)
//   pop              read side (ignored while empty)
//   head             current head word, valid while !empty
//   full, empty      occupancy flags
module cam_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cam_axi_wr_slave.sv
// AXI4 single-beat write responder at the end of the camera-to-SPI path.
// Writes to SPIADR load the RAM address register; writes to TXFIFO push a
// pixel word into an internal FWFT FIFO drained by the SPI/stream consumer.
// Ports:
//   iclk, rst                      clock, asynchronous active-high reset
//   aw_*                           write address channel (single beat only)
//   w_*                            write data channel
//   b_*                            write response channel (OKAY / SLVERR)
//   ram_addr_o, ram_addr_upd_o     last RAM address and its update pulse
//   pix_data_o/valid_o/ready_i     FIFO head stream to the consumer
//   word_cnt_o                     pixel words since the last SPIADR write
//   seq_err_o, seq_clr_i           sticky address-sequence error and clear
module cam_axi_wr_slave
  import cam_axi_pkg::*;
#(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_WDATA_WIDTH   = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter logic [31:0] TXFIFO             = TXFIFO_ADDR,
  parameter logic [31:0] SPIADR             = SPIADR_ADDR,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                          iclk,
  input  logic                          rst,
  input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                    aw_len_i,
  input  logic [2:0]                    aw_size_i,
  input  logic [1:0]                    aw_burst_i,
  input  logic                          aw_valid_i,
  output logic                          aw_ready_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   w_data_i,
  input  logic [3:0]                    w_strb_i,
  input  logic                          w_last_i,
  input  logic                          w_valid_i,
  output logic                          w_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
  output logic [1:0]                    b_resp_o,
  output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
  output logic                          b_valid_o,
  input  logic                          b_ready_i,
  output logic [31:0]                   ram_addr_o,
  output logic                          ram_addr_upd_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   pix_data_o,
  output logic                          pix_valid_o,
  input  logic                          pix_ready_i,
  output logic [15:0]                   word_cnt_o,
  output logic                          seq_err_o,
  input  logic                          seq_clr_i
);

  state_e                          state;
  state_e                          next_state;
  logic                            aw_ready_q;
  logic                            b_valid_q;
  logic [AXI4_ID_WIDTH-1:0]        id_q;
  logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q;
  logic                            err_len_q;
  logic [1:0]                      b_resp_q;
  logic [31:0]                     ram_addr_q;
  logic                            upd_q;
  logic [15:0]                     word_cnt_q;
  logic                            seq_err_q;
  logic                            first_addr_q;

  logic                            w_ready;
  logic                            aw_hs;
  logic                            w_hs;
  logic                            is_tx;
  logic                            is_spi;
  logic                            slverr;
  logic                            push;
  logic                            spi_wr;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            unused_burst;

  assign unused_burst = ^aw_burst_i;

  // Decode of the captured address and the response outcome of the W beat.
  assign is_tx  = (addr_q == AXI4_ADDRESS_WIDTH'(TXFIFO));
  assign is_spi = (addr_q == AXI4_ADDRESS_WIDTH'(SPIADR));
  assign slverr = !(is_tx || is_spi) || err_len_q || !w_last_i || (w_strb_i != 4'hF);
  assign aw_hs  = (state == IDLE) && aw_ready_q && aw_valid_i;
  assign w_hs   = (state == DATA) && w_ready && w_valid_i;
  assign push   = w_hs && !slverr && is_tx;
  assign spi_wr = w_hs && !slverr && is_spi;

  // Next-state and combinational W ready (gated on FIFO space for pixel writes).
  always_comb begin
    next_state = state;
    w_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (aw_valid_i && aw_ready_q) next_state = DATA;
      end
      DATA: begin
        w_ready = is_tx ? !fifo_full : 1'b1;
        if (w_valid_i && w_ready) next_state = RESP;
      end
      RESP: begin
        if (b_ready_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and registered channel handshake outputs.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      state      <= next_state;
      aw_ready_q <= (next_state == IDLE);
      b_valid_q  <= (next_state == RESP);
    end
  end

  // Transaction capture, response and register side effects.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      id_q         <= '0;
      addr_q       <= '0;
      err_len_q    <= 1'b0;
      b_resp_q     <= RESP_OKAY;
      ram_addr_q   <= '0;
      upd_q        <= 1'b0;
      word_cnt_q   <= '0;
      seq_err_q    <= 1'b0;
      first_addr_q <= 1'b1;
    end else begin
      if (aw_hs) begin
        id_q      <= aw_id_i;
        addr_q    <= aw_addr_i;
        err_len_q <= (aw_len_i != 8'd0) || (aw_size_i != 3'b010);
      end
      if (w_hs) b_resp_q <= slverr ? RESP_SLVERR : RESP_OKAY;

      upd_q <= spi_wr;
      if (spi_wr) ram_addr_q <= 32'(w_data_i);

      if (spi_wr) begin
        word_cnt_q <= '0;
      end else if (push && (word_cnt_q != 16'hFFFF)) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end

      // Clear wins over a same-cycle sequence error and re-arms the first write.
      if (seq_clr_i) begin
        seq_err_q    <= 1'b0;
        first_addr_q <= 1'b1;
      end else if (spi_wr) begin
        if (!first_addr_q && (32'(w_data_i) != ram_addr_q + 32'd4)) seq_err_q <= 1'b1;
        first_addr_q <= 1'b0;
      end
    end
  end

  cam_sync_fifo #(
    .WIDTH (AXI4_WDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iclk),
    .rst       (rst),
    .push      (push),
    .push_data (w_data_i),
    .pop       (pix_valid_o && pix_ready_i),
    .head      (pix_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign aw_ready_o     = aw_ready_q;
  assign w_ready_o      = w_ready;
  assign b_valid_o      = b_valid_q;
  assign b_id_o         = id_q;
  assign b_resp_o       = b_resp_q;
  assign b_user_o       = '0;
  assign ram_addr_o     = ram_addr_q;
  assign ram_addr_upd_o = upd_q;
  assign pix_valid_o    = !fifo_empty;
  assign word_cnt_o     = word_cnt_q;
  assign seq_err_o      = seq_err_q;

endmodule

// File: tb/tb_cam_axi_wr_slave.sv
// Self-checking bench for cam_axi_wr_slave: directed scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_cam_axi_wr_slave;
  import cam_axi_pkg::*;

  localparam int TMO = 60;

  logic        iclk = 1'b0;
  logic        rst;
  logic [15:0] aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid;
  logic        aw_ready_o;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        w_ready_o;
  logic [15:0] b_id_o;
  logic [1:0]  b_resp_o;
  logic [9:0]  b_user_o;
  logic        b_valid_o;
  logic        b_ready;
  logic [31:0] ram_addr_o;
  logic        ram_addr_upd_o;
  logic [31:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready;
  logic [15:0] word_cnt_o;
  logic        seq_err_o;
  logic        seq_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;

  // Consumer-side drive controls.
  logic pix_rand_en = 1'b0, pix_hold = 1'b0, clr_rand_en = 1'b0, clr_hold = 1'b0;

  // Behavioural model state.
  int          m_stage;     // 0 waiting for address, 1 waiting for data, 2 response pending
  logic        m_awr;
  logic [31:0] m_addr;
  logic        m_lenbad;
  logic [15:0] m_id;
  logic [1:0]  m_resp;
  logic [31:0] m_q[$];
  logic [31:0] m_ram;
  logic        m_upd;
  logic [15:0] m_cnt;
  logic        m_seq;
  logic        m_first;

  cam_axi_wr_slave dut (
    .iclk(iclk), .rst(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid),
    .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_user_o(b_user_o), .b_valid_o(b_valid_o),
    .b_ready_i(b_ready),
    .ram_addr_o(ram_addr_o), .ram_addr_upd_o(ram_addr_upd_o),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready),
    .word_cnt_o(word_cnt_o), .seq_err_o(seq_err_o), .seq_clr_i(seq_clr)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for handshake (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_stage = 0; m_awr = 1'b0; m_addr = '0; m_lenbad = 1'b0; m_id = '0; m_resp = 2'b00;
    m_q.delete(); m_ram = '0; m_upd = 1'b0; m_cnt = '0; m_seq = 1'b0; m_first = 1'b1;
  endtask

  // Model and per-cycle compare: outputs are stable at the falling edge, and the
  // inputs seen here are the ones the next rising edge will sample.
  initial begin
    model_reset();
    forever begin
      @(negedge iclk);
      if (rst) model_reset();
      begin
        logic wr_exp, pop, awhs, whs, bhs, err, nupd;
        wr_exp = (m_stage == 1) && ((m_addr != TXFIFO_ADDR) || (m_q.size() < 4));
        chk("aw_ready", aw_ready_o, m_awr);
        chk("w_ready", w_ready_o, wr_exp);
        chk("b_valid", b_valid_o, m_stage == 2);
        chk("b_user", b_user_o, 0);
        chk("pix_valid", pix_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) chk("pix_data", pix_data_o, m_q[0]);
        chk("ram_addr", ram_addr_o, m_ram);
        chk("ram_addr_upd", ram_addr_upd_o, m_upd);
        chk("word_cnt", word_cnt_o, m_cnt);
        chk("seq_err", seq_err_o, m_seq);
        if (m_stage == 2) begin
          chk("b_resp", b_resp_o, m_resp);
          chk("b_id", b_id_o, m_id);
        end
        if (ram_addr_upd_o) upd_seen++;
        if (!rst) begin
          pop  = (m_q.size() > 0) && pix_ready;
          awhs = m_awr && aw_valid;
          whs  = wr_exp && w_valid;
          bhs  = (m_stage == 2) && b_ready;
          nupd = 1'b0;
          if (pop) void'(m_q.pop_front());
          if (whs) begin
            err = !((m_addr == TXFIFO_ADDR) || (m_addr == SPIADR_ADDR)) || m_lenbad ||
                  !w_last || (w_strb != 4'hF);
            m_resp = err ? 2'b10 : 2'b00;
            if (!err && m_addr == TXFIFO_ADDR) begin
              m_q.push_back(w_data);
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (!err && m_addr == SPIADR_ADDR) begin
              if (!m_first && w_data != m_ram + 32'd4) m_seq = 1'b1;
              m_first = 1'b0;
              m_ram = w_data;
              m_cnt = '0;
              nupd = 1'b1;
            end
          end
          if (seq_clr) begin m_seq = 1'b0; m_first = 1'b1; end
          m_upd = nupd;
          if (awhs) begin
            m_addr = aw_addr; m_id = aw_id; m_lenbad = (aw_len != 0) || (aw_size != 3'b010);
            m_stage = 1;
          end else if (whs) begin
            m_stage = 2;
          end else if (bhs) begin
            m_stage = 0;
          end
          m_awr = (m_stage == 0);
        end
      end
    end
  end

  // Consumer and sequence-clear driver.
  initial begin
    pix_ready = 1'b0;
    seq_clr   = 1'b0;
    forever begin
      @(posedge iclk);
      #2;
      pix_ready = pix_rand_en ? ($urandom_range(0, 3) == 0) : pix_hold;
      seq_clr   = clr_rand_en ? ($urandom_range(0, 15) == 0) : clr_hold;
    end
  end

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] len,
                        input logic [2:0] size, input logic [3:0] strb, input logic last,
                        input logic [15:0] id, input int bdelay,
                        output logic [1:0] resp, output logic [15:0] bid);
    int t;
    resp = 2'b11;
    bid  = '0;
    @(posedge iclk); #1;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = 2'b01; aw_valid = 1'b1;
    t = 0;
    @(negedge iclk);
    while (!aw_ready_o && t < TMO) begin t++; @(negedge iclk); end
    if (!aw_ready_o) begin tmo("aw_handshake"); @(posedge iclk); #1 aw_valid = 1'b0; return; end
    @(posedge iclk); #1;
    aw_valid = 1'b0; w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    t = 0;
    @(negedge iclk);
    while (!w_ready_o && t < TMO) begin t++; @(negedge iclk); end
    if (!w_ready_o) begin tmo("w_handshake"); @(posedge iclk); #1 w_valid = 1'b0; return; end
    @(posedge iclk); #1;
    w_valid = 1'b0;
    b_ready = (bdelay == 0);
    t = 0;
    @(negedge iclk);
    while (!b_valid_o && t < TMO) begin t++; @(negedge iclk); end
    if (!b_valid_o) begin tmo("b_valid"); @(posedge iclk); #1 b_ready = 1'b0; return; end
    resp = b_resp_o;
    bid  = b_id_o;
    if (bdelay > 0) begin
      repeat (bdelay) @(posedge iclk);
      #1 b_ready = 1'b1;
    end
    @(posedge iclk); #1 b_ready = 1'b0;
  endtask

  task automatic pop_one();
    @(posedge iclk); #1 pix_hold = 1'b1;
    @(posedge iclk); #1 pix_hold = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge iclk); #1 clr_hold = 1'b1;
    @(posedge iclk); #1 clr_hold = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [15:0] bid;
    int          up0;
    rst = 1'b1; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    aw_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    #1;
    chk("rst_aw_ready", aw_ready_o, 0);
    chk("rst_w_ready", w_ready_o, 0);
    chk("rst_b_valid", b_valid_o, 0);
    chk("rst_b_resp", b_resp_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_word_cnt", word_cnt_o, 0);
    chk("rst_seq_err", seq_err_o, 0);
    chk("rst_pix_valid", pix_valid_o, 0);
    repeat (3) @(posedge iclk);
    #1 rst = 1'b0;

    // Single SPIADR write.
    up0 = upd_seen;
    axi_wr(SPIADR_ADDR, 32'h7FF, 8'd0, 3'b010, 4'hF, 1'b1, 16'h1234, 0, resp, bid);
    chk("t1_resp", resp, 2'b00);
    chk("t1_bid", bid, 16'h1234);
    @(negedge iclk);
    chk("t1_ram_addr", ram_addr_o, 32'h7FF);
    chk("t1_word_cnt", word_cnt_o, 0);
    chk("t1_upd_pulses", upd_seen - up0, 1);

    // Fill the FIFO, then stall a fifth write until one pop.
    for (int i = 1; i <= 4; i++)
      axi_wr(TXFIFO_ADDR, 32'h11 * i, 8'd0, 3'b010, 4'hF, 1'b1, 16'(i), 0, resp, bid);
    @(negedge iclk);
    chk("t2_full_head", pix_data_o, 32'h11);
    chk("t2_cnt4", word_cnt_o, 4);
    fork
      axi_wr(TXFIFO_ADDR, 32'h55, 8'd0, 3'b010, 4'hF, 1'b1, 16'h5, 0, resp, bid);
      begin
        repeat (4) @(negedge iclk);
        chk("t2_stall_w_ready", w_ready_o, 0);
        chk("t2_stall_head", pix_data_o, 32'h11);
        pop_one();
      end
    join
    chk("t2_fifth_resp", resp, 2'b00);
    for (int i = 2; i <= 5; i++) begin
      @(negedge iclk);
      chk("t2_pop_order", pix_data_o, 32'h11 * i);
      pop_one();
    end
    @(negedge iclk);
    chk("t2_drained", pix_valid_o, 0);
    chk("t2_cnt5", word_cnt_o, 5);

    // Address sequence checking, including 32-bit wrap.
    clr_pulse();
    axi_wr(SPIADR_ADDR, 32'h7FF, 8'd0, 3'b010, 4'hF, 1'b1, 16'h1, 0, resp, bid);
    axi_wr(SPIADR_ADDR, 32'h803, 8'd0, 3'b010, 4'hF, 1'b1, 16'h2, 0, resp, bid);
    @(negedge iclk);
    chk("t3_in_seq", seq_err_o, 0);
    axi_wr(SPIADR_ADDR, 32'h900, 8'd0, 3'b010, 4'hF, 1'b1, 16'h3, 0, resp, bid);
    @(negedge iclk);
    chk("t3_out_of_seq", seq_err_o, 1);
    clr_pulse();
    @(negedge iclk);
    chk("t3_cleared", seq_err_o, 0);
    axi_wr(SPIADR_ADDR, 32'hFFFF_FFFC, 8'd0, 3'b010, 4'hF, 1'b1, 16'h4, 0, resp, bid);
    axi_wr(SPIADR_ADDR, 32'h0, 8'd0, 3'b010, 4'hF, 1'b1, 16'h5, 0, resp, bid);
    @(negedge iclk);
    chk("t3_wrap_seq", seq_err_o, 0);
    chk("t3_wrap_addr", ram_addr_o, 0);

    // Error responses leave no side effects.
    axi_wr(32'h0, 32'hDEAD_BEEF, 8'd0, 3'b010, 4'hF, 1'b1, 16'hA, 0, resp, bid);
    chk("t4_unmapped", resp, 2'b10);
    axi_wr(TXFIFO_ADDR, 32'h66, 8'd1, 3'b010, 4'hF, 1'b1, 16'hB, 0, resp, bid);
    chk("t4_len", resp, 2'b10);
    axi_wr(TXFIFO_ADDR, 32'h77, 8'd0, 3'b010, 4'h3, 1'b1, 16'hC, 0, resp, bid);
    chk("t4_strb", resp, 2'b10);
    axi_wr(TXFIFO_ADDR, 32'h88, 8'd0, 3'b010, 4'hF, 1'b0, 16'hD, 0, resp, bid);
    chk("t4_last", resp, 2'b10);
    axi_wr(SPIADR_ADDR, 32'h4, 8'd0, 3'b001, 4'hF, 1'b1, 16'hE, 0, resp, bid);
    chk("t4_size", resp, 2'b10);
    @(negedge iclk);
    chk("t4_no_push", pix_valid_o, 0);
    chk("t4_no_cnt", word_cnt_o, 0);
    chk("t4_no_ram", ram_addr_o, 0);

    // Response back-pressure.
    fork
      axi_wr(SPIADR_ADDR, 32'h4, 8'd0, 3'b010, 4'hF, 1'b1, 16'hBEEF, 5, resp, bid);
      begin
        int t;
        t = 0;
        @(negedge iclk);
        while (!b_valid_o && t < TMO) begin t++; @(negedge iclk); end
        for (int i = 0; i < 5; i++) begin
          chk("t5_b_valid_held", b_valid_o, 1);
          chk("t5_aw_ready_low", aw_ready_o, 0);
          if (i < 4) @(negedge iclk);
        end
      end
    join
    chk("t5_resp", resp, 2'b00);
    chk("t5_bid", bid, 16'hBEEF);
    @(negedge iclk);
    chk("t5_idle_after", aw_ready_o, 1);

    // Reset in the data phase.
    axi_wr(TXFIFO_ADDR, 32'hA1, 8'd0, 3'b010, 4'hF, 1'b1, 16'h1, 0, resp, bid);
    axi_wr(TXFIFO_ADDR, 32'hA2, 8'd0, 3'b010, 4'hF, 1'b1, 16'h2, 0, resp, bid);
    @(posedge iclk); #1;
    aw_addr = SPIADR_ADDR; aw_id = 16'h77; aw_len = 8'd0; aw_size = 3'b010; aw_valid = 1'b1;
    @(negedge iclk);
    chk("t6_aw_ready", aw_ready_o, 1);
    @(posedge iclk); #1 aw_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_aw_ready", aw_ready_o, 0);
    chk("t6_rst_w_ready", w_ready_o, 0);
    chk("t6_rst_b_valid", b_valid_o, 0);
    chk("t6_rst_pix_valid", pix_valid_o, 0);
    chk("t6_rst_word_cnt", word_cnt_o, 0);
    chk("t6_rst_ram_addr", ram_addr_o, 0);
    @(posedge iclk); #1 rst = 1'b0;
    axi_wr(TXFIFO_ADDR, 32'hABCD, 8'd0, 3'b010, 4'hF, 1'b1, 16'h9, 0, resp, bid);
    chk("t6_after_resp", resp, 2'b00);
    @(negedge iclk);
    chk("t6_after_head", pix_data_o, 32'hABCD);
    chk("t6_after_cnt", word_cnt_o, 1);

    // Randomized traffic with a random consumer and random clears.
    pix_rand_en = 1'b1;
    clr_rand_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a, d;
      logic [7:0]  l;
      logic [2:0]  s;
      logic [3:0]  st;
      logic        lst, err;
      logic [15:0] id;
      int          k;
      k = $urandom_range(0, 9);
      if (k <= 5) a = TXFIFO_ADDR;
      else if (k <= 8) a = SPIADR_ADDR;
      else begin
        a = $urandom;
        if (a == TXFIFO_ADDR || a == SPIADR_ADDR) a = a ^ 32'h1;
      end
      d   = ($urandom_range(0, 1) == 1) ? m_ram + 32'd4 : $urandom;
      l   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      s   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      st  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      lst = ($urandom_range(0, 19) != 0);
      id  = 16'($urandom);
      err = !((a == TXFIFO_ADDR) || (a == SPIADR_ADDR)) || (l != 0) || (s != 3'b010) ||
            !lst || (st != 4'hF);
      axi_wr(a, d, l, s, st, lst, id, $urandom_range(0, 3), resp, bid);
      chk("rand_resp", resp, err ? 2'b10 : 2'b00);
      chk("rand_bid", bid, id);
    end
    pix_rand_en = 1'b0;
    clr_rand_en = 1'b0;
    repeat (4) @(posedge iclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
